// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD adder/subtractor.
package bcd_pkg;

  typedef logic [3:0] digit_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Decimal adjust applied when a digit overflows or underflows
  localparam digit_t BCD_CORR = 4'd6;

  // A BCD digit is legal only in the range 0..9
  function automatic logic digit_bad(input digit_t v);
    return v > 4'd9;
  endfunction

endpackage

// File: rtl/bcd_digit_addsub.sv
// Single-digit combinational BCD add/subtract with decimal correction.
module bcd_digit_addsub
  import bcd_pkg::*;
(
  input  digit_t x,
  input  digit_t y,
  input  op_t    op,
  input  logic   c_in,
  output digit_t d,
  output logic   c_out,
  output logic   bad
);

  logic [4:0] raw;

  // Binary add/sub of one digit, then correct into BCD and derive carry/borrow
  always_comb begin
    raw   = '0;
    d     = '0;
    c_out = 1'b0;
    bad   = digit_bad(x) | digit_bad(y);
    if (op == OP_ADD) begin
      raw = {1'b0, x} + {1'b0, y} + {4'b0, c_in};
      if (raw > 5'd9) begin
        d     = raw[3:0] + BCD_CORR;
        c_out = 1'b1;
      end else begin
        d = raw[3:0];
      end
    end else begin
      raw = {1'b0, x} - {1'b0, y} - {4'b0, c_in};
      if (raw[4]) begin
        d     = raw[3:0] - BCD_CORR;
        c_out = 1'b1;
      end else begin
        d = raw[3:0];
      end
    end
  end

endmodule

// File: rtl/bcd_addsub_serial.sv
// Digit-serial BCD adder/subtractor: one digit per clock, LSD first,
// valid/ready handshakes on both operand and result sides.
module bcd_addsub_serial
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned CNT_W  = $clog2(DIGITS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                op,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] result,
  output logic                cout,
  output logic                err,
  output logic                busy
);

  localparam int unsigned W = 4 * DIGITS;

  state_t           state;
  logic [W-1:0]     a_sh;
  logic [W-1:0]     b_sh;
  op_t              op_r;
  logic             c_r;
  logic [CNT_W-1:0] cnt;

  digit_t           dig;
  logic             dig_c;
  logic             dig_bad;
  logic             accept;
  logic             last;

  // Operands are accepted when idle, or when the held result is being taken
  always_comb begin
    in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    accept   = in_valid && in_ready;
    last     = (cnt == CNT_W'(DIGITS - 1));
  end

  bcd_digit_addsub u_digit (
    .x     (a_sh[3:0]),
    .y     (b_sh[3:0]),
    .op    (op_r),
    .c_in  (c_r),
    .d     (dig),
    .c_out (dig_c),
    .bad   (dig_bad)
  );

  // Control FSM plus operand shift registers and result assembly.
  // Accept is checked ahead of the state case so a DONE->CALC handoff
  // and an IDLE->CALC start share one load path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      op_r      <= OP_ADD;
      c_r       <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      cout      <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (accept) begin
      a_sh      <= a;
      b_sh      <= b;
      op_r      <= op_t'(op);
      c_r       <= cin;
      cnt       <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b1;
      state     <= CALC;
    end else begin
      case (state)
        CALC: begin
          a_sh <= a_sh >> 4;
          b_sh <= b_sh >> 4;
          c_r  <= dig_c;
          err  <= err | dig_bad;
          cnt  <= cnt + CNT_W'(1);
          for (int unsigned i = 0; i < DIGITS; i++) begin
            if (cnt == CNT_W'(i)) result[4*i +: 4] <= dig;
          end
          if (last) begin
            cout      <= dig_c;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Directed self-checking bench for bcd_addsub_serial (DIGITS = 4).
module tb_bcd_addsub_serial;

  localparam int unsigned DIGITS = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        cout;
  logic        err;
  logic        busy;

  int n_asrt = 0;
  int n_fail = 0;

  bcd_addsub_serial #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .err       (err),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand set for a single accepting edge
  task automatic issue(input logic o, input logic [15:0] x, input logic [15:0] y, input logic c);
    chk("in_ready_before_issue", 16'(in_ready), 16'd1);
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    cin = c;
    tick();
    in_valid = 1'b0;
    chk("busy_after_accept", 16'(busy), 16'd1);
    chk("out_valid_after_accept", 16'(out_valid), 16'd0);
  endtask

  // Wait out the digit cycles with junk offered on the input (must be ignored),
  // then check the latency and the final values.
  task automatic expect_done(input string tag, input logic [15:0] res,
                             input logic c, input logic e, input logic chk_res);
    in_valid = 1'b1;
    op = 1'b1;
    a = 16'h8888;
    b = 16'h8888;
    cin = 1'b1;
    for (int k = 1; k < int'(DIGITS); k++) begin
      chk("in_ready_in_calc", 16'(in_ready), 16'd0);
      tick();
      chk("out_valid_early", 16'(out_valid), 16'd0);
    end
    tick();
    in_valid = 1'b0;
    chk({tag, "_out_valid"}, 16'(out_valid), 16'd1);
    chk({tag, "_busy"}, 16'(busy), 16'd0);
    if (chk_res) chk({tag, "_result"}, result, res);
    if (chk_res) chk({tag, "_cout"}, 16'(cout), 16'(c));
    chk({tag, "_err"}, 16'(err), 16'(e));
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid_after_pop", 16'(out_valid), 16'd0);
    chk("in_ready_after_pop", 16'(in_ready), 16'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;

    // Reset state
    #3;
    chk("rst_result", result, 16'h0000);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_cout", 16'(cout), 16'd0);
    chk("rst_err", 16'(err), 16'd0);
    #9;
    rst_n = 1'b1;
    tick();
    chk("in_ready_post_reset", 16'(in_ready), 16'd1);

    // 1234 - 0567 = 0667
    issue(1'b1, 16'h1234, 16'h0567, 1'b0);
    expect_done("sub_1234_0567", 16'h0667, 1'b0, 1'b0, 1'b1);
    pop();

    // 0000 - 0001 = 9999, borrow out
    issue(1'b1, 16'h0000, 16'h0001, 1'b0);
    expect_done("sub_0_1", 16'h9999, 1'b1, 1'b0, 1'b1);
    pop();

    // 9999 + 0000 + 1 = 0000, carry out
    issue(1'b0, 16'h9999, 16'h0000, 1'b1);
    expect_done("add_9999_cin", 16'h0000, 1'b1, 1'b0, 1'b1);
    pop();

    // Carry ripple: 0999 + 0001 = 1000
    issue(1'b0, 16'h0999, 16'h0001, 1'b0);
    expect_done("add_0999_1", 16'h1000, 1'b0, 1'b0, 1'b1);
    pop();

    // Illegal digit raises err; value not checked
    issue(1'b0, 16'h12A4, 16'h0001, 1'b0);
    expect_done("err_digit", 16'h0000, 1'b0, 1'b1, 1'b0);
    pop();

    // Clean transaction clears err
    issue(1'b0, 16'h0123, 16'h0456, 1'b0);
    expect_done("add_0123_0456", 16'h0579, 1'b0, 1'b0, 1'b1);

    // Backpressure: result held, new operands waiting
    in_valid = 1'b1;
    op = 1'b0;
    a = 16'h5678;
    b = 16'h4321;
    cin = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("bp_in_ready", 16'(in_ready), 16'd0);
      tick();
      chk("bp_result_hold", result, 16'h0579);
      chk("bp_out_valid_hold", 16'(out_valid), 16'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_release", 16'(in_ready), 16'd1);
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("b2b_busy", 16'(busy), 16'd1);
    chk("b2b_out_valid", 16'(out_valid), 16'd0);
    expect_done("b2b_5678_4321", 16'h9999, 1'b0, 1'b0, 1'b1);
    pop();

    // Reset after two digit cycles drops the transaction
    issue(1'b0, 16'h1111, 16'h2222, 1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_result", result, 16'h0000);
    chk("midrst_out_valid", 16'(out_valid), 16'd0);
    chk("midrst_busy", 16'(busy), 16'd0);
    chk("midrst_cout", 16'(cout), 16'd0);
    chk("midrst_err", 16'(err), 16'd0);
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    chk("midrst_in_ready", 16'(in_ready), 16'd1);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("midrst_no_out_valid", 16'(out_valid), 16'd0);
    end

    // Borrow chain after reset: 5000 - 0001 - 1 = 4998
    issue(1'b1, 16'h5000, 16'h0001, 1'b1);
    expect_done("sub_5000_1_bin", 16'h4998, 1'b0, 1'b0, 1'b1);
    pop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_addsub_serial.md
BCD_ADDSUB_SERIAL -- requirements
Module: bcd_addsub_serial

Interface
REQ-001 SHALL have parameter DIGITS, default 4 (>=1): number of BCD digits per operand.
REQ-002 SHALL have parameter CNT_W, default $clog2(DIGITS+1): digit counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand set present.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 op  input  1  0 = add (a+b+cin), 1 = subtract (a-b-cin).
REQ-008 a  input  4*DIGITS  operand A, digit 0 in bits [3:0].
REQ-009 b  input  4*DIGITS  operand B, same packing.
REQ-010 cin  input  1  carry-in (add) or borrow-in (subtract).
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer takes result this cycle.
REQ-013 result  output  4*DIGITS  BCD sum or difference.
REQ-014 cout  output  1  final carry (add) or final borrow (subtract).
REQ-015 err  output  1  some operand digit was >9.
REQ-016 busy  output  1  high in CALC.

Function
REQ-017 FSM states SHALL be IDLE, CALC, DONE.
REQ-018 in_ready SHALL be 1 in IDLE, and in DONE when out_ready=1; 0 otherwise.
REQ-019 Accept = in_valid & in_ready; on accept, a, b, op, cin SHALL be registered, digit counter cleared, err cleared, state -> CALC.
REQ-020 In CALC, one digit per cycle, LSD first: digit i of a and b SHALL combine with running carry/borrow; BCD-corrected digit stored to result slot i; carry/borrow updated.
REQ-021 Add: raw = a_i+b_i+c; raw>9 -> digit = raw+6 (mod 16), carry 1; else carry 0.
REQ-022 Subtract: raw = a_i-b_i-c (5-bit); negative -> digit = raw-6 (mod 16), borrow 1; else borrow 0.
REQ-023 Subtract with final borrow 1 SHALL yield ten's complement in result (0000-0001 = 9999, cout=1); no sign-magnitude conversion.
REQ-024 After digit DIGITS-1, state -> DONE; out_valid SHALL rise exactly DIGITS rising edges after accept edge.
REQ-025 In DONE, result, cout, err SHALL hold stable until out_valid & out_ready.
REQ-026 out_valid & out_ready with in_valid=0 -> IDLE, out_valid 0 next cycle.
REQ-027 out_valid & out_ready with in_valid=1 SHALL accept new operands same cycle (back-to-back, no bubble) -> CALC.
REQ-028 in_valid in CALC SHALL be ignored; operands not captured.
REQ-029 err SHALL be set during CALC if a_i>9 or b_i>9; result still computed per REQ-021/022, value not checked when err=1.
REQ-030 result SHALL hold previous value outside DONE; only valid with out_valid.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, result=0, cout=0, err=0, out_valid=0, busy=0, counter=0, operand registers=0.
REQ-032 Reset mid-CALC or in DONE SHALL drop the transaction; no out_valid follows.
REQ-033 in_ready SHALL be 1 on first rising edge after rst_n deasserts.

Structure
REQ-034 Shared package bcd_pkg SHALL hold: digit type (4 bits), op encoding (OP_ADD=0, OP_SUB=1), FSM state enum, constant BCD_CORR=6.
REQ-035 One sub-module bcd_digit_addsub SHALL implement single-digit combinational add/sub with correction (inputs x, y, op, c_in; outputs d, c_out, bad); top holds FSM, counter, shift/operand registers.

Verification
REQ-036 DIGITS=4, op=1, a=0x1234, b=0x0567, cin=0 -> result 0x0667, cout 0, out_valid 4 edges after accept.
REQ-037 op=1, a=0x0000, b=0x0001, cin=0 -> result 0x9999, cout 1, err 0.
REQ-038 op=0, a=0x9999, b=0x0000, cin=1 -> result 0x0000, cout 1.
REQ-039 Backpressure: out_ready=0 for 3 cycles in DONE, in_valid=1 -> result stable, in_ready 0; out_ready=1 with in_valid=1 -> new operands accepted same edge.
REQ-040 rst_n pulsed after 2 CALC cycles -> outputs zero asynchronously, no out_valid, in_ready=1 after release.
REQ-041 op=0, a=0x12A4, b=0x0001 -> err 1 with out_valid; next clean transaction -> err 0.
